// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing controller.
// Contents: FSM state enum, pc_sel / wb_sel encodings, RV32I major opcodes and
// a helper that classifies an opcode as supported by this core.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // PC source select
    localparam logic [1:0] PC_SEL_PLUS4   = 2'd0;  // pc + 4
    localparam logic [1:0] PC_SEL_PC_IMM  = 2'd1;  // pc + imm (branch / JAL)
    localparam logic [1:0] PC_SEL_RS1_IMM = 2'd2;  // rs1 + imm (JALR)

    // Register-file writeback source select
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic logic is_supported(input logic [6:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory request-ready handshake bundle for the controller.
// master: controller side (drives requests, receives ready).
// slave : memory side (receives requests, drives ready).
interface multicycle_ctrl_if;
    logic imem_req;    // instruction fetch request, held until imem_ready
    logic imem_ready;  // fetch data valid this cycle
    logic dmem_req;    // data access request, held until dmem_ready
    logic dmem_we;     // data access is a store
    logic dmem_ready;  // data access completes this cycle

    modport master (
        output imem_req,
        input  imem_ready,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory-wait watchdog counter shared by the FETCH and MEM states.
// Latency: expired is combinational from the current count and inc.
// Backpressure: none; counts cycles in which a request is stalled by ready=0.
// Ports: clk, rst (async active-low), clr (restart count), inc (stalled cycle),
//        expired (this stalled cycle brings the count to TIMEOUT_CYCLES).
module multicycle_ctrl_wait_timer #(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    // Count value at the start of the final allowed stalled cycle.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Only a stalled cycle can expire, so a ready arriving on the limit
    // cycle wins and the access completes normally.
    assign expired = inc && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multi-cycle RV32I core: IR/PC/RF/ALU/memory control.
// Latency: ALU/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, BRANCH/NOP 3 cycles + waits.
// Backpressure: requests held until ready; watchdog halts after TIMEOUT_CYCLES stalls.
// Ports: clk, rst (async active-low), en, opcode, branch_taken, mem (handshakes),
//        ir_we, pc_we, pc_sel, alu_srcb_imm, rf_we, wb_sel, instret, illegal,
//        timeout, state (debug).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [6:0]                opcode,
    input  logic                      branch_taken,
    multicycle_ctrl_if.master         mem,
    output logic                      ir_we,
    output logic                      pc_we,
    output logic [1:0]                pc_sel,
    output logic                      alu_srcb_imm,
    output logic                      rf_we,
    output logic [1:0]                wb_sel,
    output logic [31:0]               instret,
    output logic                      illegal,
    output logic                      timeout,
    output logic [2:0]                state
);

    state_t state_q;
    state_t state_d;

    logic imem_req_c;
    logic dmem_req_c;
    logic dmem_we_c;
    logic retire;
    logic set_illegal;
    logic set_timeout;
    logic wait_inc;
    logic wait_clr;
    logic wait_expired;

    // A stalled cycle: the active request sees no ready. Derived from the
    // state and the ready inputs only, so the watchdog has no path back
    // through the next-state logic.
    assign wait_inc = ((state_q == ST_FETCH) && !mem.imem_ready) ||
                      ((state_q == ST_MEM)   && !mem.dmem_ready);

    // Every entry into FETCH or MEM is a state change (including the
    // direct MEM -> FETCH hop of a retiring store), so restart on any change.
    assign wait_clr = (state_d != state_q);

    multicycle_ctrl_wait_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_clr),
        .inc     (wait_inc),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            instret <= '0;
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret <= instret + 32'd1;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        dmem_we_c    = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_SEL_PLUS4;
        alu_srcb_imm = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_SEL_ALU;
        retire       = 1'b0;
        set_illegal  = 1'b0;
        set_timeout  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    set_timeout = 1'b1;
                    state_d     = ST_HALT;
                end
            end

            ST_DECODE: begin
                if (is_supported(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = ST_HALT;
                end
            end

            ST_EXEC: begin
                alu_srcb_imm = (opcode != OPC_OP) && (opcode != OPC_BRANCH);
                case (opcode)
                    OPC_LOAD, OPC_STORE: begin
                        state_d = ST_MEM;
                    end
                    OPC_BRANCH: begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? PC_SEL_PC_IMM : PC_SEL_PLUS4;
                        retire = 1'b1;
                    end
                    OPC_MISC_MEM, OPC_SYSTEM: begin
                        // FENCE / ECALL / EBREAK / CSR: no architectural effect here.
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                    default: begin
                        state_d = ST_WB;
                    end
                endcase
            end

            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (opcode == OPC_STORE);
                if (mem.dmem_ready) begin
                    if (opcode == OPC_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_expired) begin
                    set_timeout = 1'b1;
                    state_d     = ST_HALT;
                end
            end

            ST_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                case (opcode)
                    OPC_LOAD: wb_sel = WB_SEL_LOAD;
                    OPC_JAL:  begin
                        wb_sel = WB_SEL_PC4;
                        pc_sel = PC_SEL_PC_IMM;
                    end
                    OPC_JALR: begin
                        wb_sel = WB_SEL_PC4;
                        pc_sel = PC_SEL_RS1_IMM;
                    end
                    default:  wb_sel = WB_SEL_ALU;
                endcase
            end

            ST_HALT: begin
                // Terminal: only reset leaves this state.
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_HALT;
            end
        endcase

        // en is sampled at retirement so an in-flight instruction always
        // completes before the core parks in IDLE.
        if (retire) begin
            state_d = en ? ST_FETCH : ST_IDLE;
        end
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;
    assign state        = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (TIMEOUT_CYCLES = 4).
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        branch_taken = 1'b0;
    logic        ir_we, pc_we, alu_srcb_imm, rf_we, illegal, timeout;
    logic [1:0]  pc_sel, wb_sel;
    logic [31:0] instret;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_ctrl_if mem_if ();

    multicycle_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem          (mem_if),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .alu_srcb_imm (alu_srcb_imm),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .instret      (instret),
        .illegal      (illegal),
        .timeout      (timeout),
        .state        (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        mem_if.imem_ready = 1'b0;
        mem_if.dmem_ready = 1'b0;

        // Async reset asserted between edges.
        #1 rst = 1'b0;
        #2;
        chk("rst_state",   32'(state),          32'd0);
        chk("rst_instret", instret,             32'd0);
        chk("rst_illegal", 32'(illegal),        32'd0);
        chk("rst_timeout", 32'(timeout),        32'd0);
        chk("rst_imem",    32'(mem_if.imem_req), 32'd0);
        chk("rst_dmem",    32'(mem_if.dmem_req), 32'd0);
        chk("rst_pc_we",   32'(pc_we),          32'd0);
        chk("rst_rf_we",   32'(rf_we),          32'd0);
        cyc(); rst = 1'b1;
        cyc();

        // ADDI, immediate fetch ready: 1,2,3,5,1
        en = 1'b1; mem_if.imem_ready = 1'b1; opcode = OPC_OP_IMM;
        settle();
        chk("addi_idle", 32'(state), 32'd0);
        cyc(); chk("addi_fetch_st", 32'(state), 32'd1);
        chk("addi_fetch_req", 32'(mem_if.imem_req), 32'd1);
        chk("addi_fetch_irwe", 32'(ir_we), 32'd1);
        chk("addi_fetch_pcwe", 32'(pc_we), 32'd0);
        cyc(); chk("addi_dec_st", 32'(state), 32'd2);
        chk("addi_dec_req", 32'(mem_if.imem_req), 32'd0);
        chk("addi_dec_rfwe", 32'(rf_we), 32'd0);
        cyc(); chk("addi_exec_st", 32'(state), 32'd3);
        chk("addi_exec_imm", 32'(alu_srcb_imm), 32'd1);
        chk("addi_exec_pcwe", 32'(pc_we), 32'd0);
        chk("addi_exec_rfwe", 32'(rf_we), 32'd0);
        cyc(); chk("addi_wb_st", 32'(state), 32'd5);
        chk("addi_wb_rfwe", 32'(rf_we), 32'd1);
        chk("addi_wb_pcwe", 32'(pc_we), 32'd1);
        chk("addi_wb_sel", 32'(wb_sel), 32'd0);
        chk("addi_wb_instret", instret, 32'd0);
        cyc(); chk("addi_next_st", 32'(state), 32'd1);
        chk("addi_instret", instret, 32'd1);

        // LW with dmem_ready on the 4th MEM cycle
        opcode = OPC_LOAD;
        cyc(); chk("lw_dec_st", 32'(state), 32'd2);
        cyc(); chk("lw_exec_imm", 32'(alu_srcb_imm), 32'd1);
        cyc(); chk("lw_mem1_st", 32'(state), 32'd4);
        chk("lw_mem1_req", 32'(mem_if.dmem_req), 32'd1);
        chk("lw_mem1_we", 32'(mem_if.dmem_we), 32'd0);
        cyc(); chk("lw_mem2_req", 32'(mem_if.dmem_req), 32'd1);
        cyc(); chk("lw_mem3_req", 32'(mem_if.dmem_req), 32'd1);
        cyc(); mem_if.dmem_ready = 1'b1; settle();
        chk("lw_mem4_st", 32'(state), 32'd4);
        chk("lw_mem4_req", 32'(mem_if.dmem_req), 32'd1);
        cyc(); mem_if.dmem_ready = 1'b0; settle();
        chk("lw_wb_st", 32'(state), 32'd5);
        chk("lw_wb_sel", 32'(wb_sel), 32'd1);
        chk("lw_wb_rfwe", 32'(rf_we), 32'd1);
        chk("lw_wb_req", 32'(mem_if.dmem_req), 32'd0);
        cyc(); chk("lw_next_st", 32'(state), 32'd1);
        chk("lw_instret", instret, 32'd2);

        // BEQ taken
        opcode = OPC_BRANCH; branch_taken = 1'b1;
        cyc(); cyc();
        chk("beq_t_st", 32'(state), 32'd3);
        chk("beq_t_pcwe", 32'(pc_we), 32'd1);
        chk("beq_t_pcsel", 32'(pc_sel), 32'd1);
        chk("beq_t_rfwe", 32'(rf_we), 32'd0);
        chk("beq_t_imm", 32'(alu_srcb_imm), 32'd0);
        cyc(); chk("beq_t_next", 32'(state), 32'd1);
        chk("beq_t_instret", instret, 32'd3);

        // BEQ not taken
        branch_taken = 1'b0;
        cyc(); cyc();
        chk("beq_n_pcwe", 32'(pc_we), 32'd1);
        chk("beq_n_pcsel", 32'(pc_sel), 32'd0);
        chk("beq_n_rfwe", 32'(rf_we), 32'd0);
        cyc(); chk("beq_n_next", 32'(state), 32'd1);
        chk("beq_n_instret", instret, 32'd4);

        // JALR
        opcode = OPC_JALR;
        cyc(); cyc(); cyc();
        chk("jalr_wb_st", 32'(state), 32'd5);
        chk("jalr_pcsel", 32'(pc_sel), 32'd2);
        chk("jalr_wbsel", 32'(wb_sel), 32'd2);
        chk("jalr_rfwe", 32'(rf_we), 32'd1);
        cyc(); chk("jalr_instret", instret, 32'd5);

        // OP (register operand B)
        opcode = OPC_OP;
        cyc(); cyc();
        chk("op_exec_imm", 32'(alu_srcb_imm), 32'd0);
        cyc(); chk("op_wbsel", 32'(wb_sel), 32'd0);
        chk("op_pcsel", 32'(pc_sel), 32'd0);
        cyc(); chk("op_instret", instret, 32'd6);

        // JAL
        opcode = OPC_JAL;
        cyc(); cyc(); cyc();
        chk("jal_pcsel", 32'(pc_sel), 32'd1);
        chk("jal_wbsel", 32'(wb_sel), 32'd2);
        cyc(); chk("jal_instret", instret, 32'd7);

        // Illegal opcode
        opcode = 7'h7F;
        cyc(); chk("ill_dec_st", 32'(state), 32'd2);
        cyc(); chk("ill_halt_st", 32'(state), 32'd6);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_req", 32'(mem_if.imem_req), 32'd0);
        chk("ill_instret", instret, 32'd7);
        cyc(); cyc();
        chk("ill_hold_st", 32'(state), 32'd6);
        chk("ill_hold_req", 32'(mem_if.imem_req), 32'd0);
        chk("ill_hold_irwe", 32'(ir_we), 32'd0);
        chk("ill_hold_instret", instret, 32'd7);

        // Fetch watchdog expiry
        rst = 1'b0; settle();
        chk("rst2_state", 32'(state), 32'd0);
        chk("rst2_illegal", 32'(illegal), 32'd0);
        chk("rst2_instret", instret, 32'd0);
        cyc(); rst = 1'b1; en = 1'b1; mem_if.imem_ready = 1'b0;
        cyc(); chk("to_w1_req", 32'(mem_if.imem_req), 32'd1);
        cyc(); cyc(); cyc();
        chk("to_w4_st", 32'(state), 32'd1);
        chk("to_w4_flag", 32'(timeout), 32'd0);
        chk("to_w4_req", 32'(mem_if.imem_req), 32'd1);
        cyc(); chk("to_halt_st", 32'(state), 32'd6);
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_req", 32'(mem_if.imem_req), 32'd0);
        chk("to_illegal", 32'(illegal), 32'd0);

        // Ready arrives on the limit cycle
        rst = 1'b0; settle();
        chk("rst3_timeout", 32'(timeout), 32'd0);
        chk("rst3_state", 32'(state), 32'd0);
        cyc(); rst = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        mem_if.imem_ready = 1'b1; opcode = OPC_STORE; settle();
        chk("lim_w4_st", 32'(state), 32'd1);
        chk("lim_irwe", 32'(ir_we), 32'd1);
        cyc(); chk("lim_dec_st", 32'(state), 32'd2);
        chk("lim_timeout", 32'(timeout), 32'd0);

        // SW with en dropped during MEM
        cyc();
        cyc(); en = 1'b0; mem_if.dmem_ready = 1'b0; settle();
        chk("sw_mem_st", 32'(state), 32'd4);
        chk("sw_mem_req", 32'(mem_if.dmem_req), 32'd1);
        chk("sw_mem_we", 32'(mem_if.dmem_we), 32'd1);
        cyc(); mem_if.dmem_ready = 1'b1; settle();
        chk("sw_done_pcwe", 32'(pc_we), 32'd1);
        chk("sw_done_pcsel", 32'(pc_sel), 32'd0);
        chk("sw_done_rfwe", 32'(rf_we), 32'd0);
        cyc(); mem_if.dmem_ready = 1'b0; settle();
        chk("sw_idle_st", 32'(state), 32'd0);
        chk("sw_instret", instret, 32'd1);
        chk("sw_idle_req", 32'(mem_if.imem_req), 32'd0);
        cyc(); chk("sw_idle_hold", 32'(state), 32'd0);

        // SYSTEM as NOP, then async reset in the middle of a FETCH
        en = 1'b1; opcode = OPC_SYSTEM; mem_if.imem_ready = 1'b1;
        cyc(); cyc(); cyc();
        chk("sys_exec_st", 32'(state), 32'd3);
        chk("sys_pcwe", 32'(pc_we), 32'd1);
        chk("sys_pcsel", 32'(pc_sel), 32'd0);
        chk("sys_rfwe", 32'(rf_we), 32'd0);
        cyc(); mem_if.imem_ready = 1'b0; settle();
        chk("sys_instret", instret, 32'd2);
        cyc(); chk("arst_pre_st", 32'(state), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_instret", instret, 32'd0);
        chk("arst_req", 32'(mem_if.imem_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
